// File: rtl/seg_scheduler_if.sv
// -----------------------------------------------------------------------------
// seg_scheduler_if
// Bundles the two handshakes around the segment scheduler:
//   command side : seg_validH, seg_x, seg_y  -> seg_readyH
//   interpolator : Xe, Ye, change_readyH     -> X_acc/X_dec/Y_acc/Y_dec, draw_overH
// Modports:
//   slave  - the scheduler's view (accepts segments, drives the interpolator)
//   master - the environment's view (command source plus interpolator)
//
// Handshake semantics: a segment transfers on a rising clock edge where
// seg_validH and seg_readyH are both high; seg_x/seg_y are sampled on that
// edge. The interpolator side is not a valid/ready pair: change_readyH is a
// one-cycle start strobe with Xe/Ye stable from then until the next pop, and
// draw_overH is the interpolator's completion flag.
// -----------------------------------------------------------------------------
interface seg_scheduler_if;
  logic        seg_validH;
  logic [15:0] seg_x;
  logic [15:0] seg_y;
  logic        seg_readyH;
  logic [15:0] Xe;
  logic [15:0] Ye;
  logic        change_readyH;
  logic        X_acc;
  logic        X_dec;
  logic        Y_acc;
  logic        Y_dec;
  logic        draw_overH;

  modport slave (
    input  seg_validH, seg_x, seg_y,
    input  X_acc, X_dec, Y_acc, Y_dec, draw_overH,
    output seg_readyH, Xe, Ye, change_readyH
  );

  modport master (
    output seg_validH, seg_x, seg_y,
    output X_acc, X_dec, Y_acc, Y_dec, draw_overH,
    input  seg_readyH, Xe, Ye, change_readyH
  );
endinterface

// File: rtl/seg_scheduler.sv
// -----------------------------------------------------------------------------
// seg_scheduler
// Buffers relative line segments in a circular FIFO, issues them one at a time
// to the line interpolator, enforces an idle gap after each segment, integrates
// the step pulses into an absolute position and watches every issued segment
// with a timeout.
//
// Ports:
//   pulse_clk      clock, rising edge
//   sys_rstH       synchronous active-high reset
//   bus            seg_scheduler_if.slave (segment input + interpolator drive)
//   abortH         flush the queue (a running segment still completes)
//   fault_clrH     leave FAULT back to IDLE
//   pos_ldH        load pos_x/pos_y from seg_x/seg_y (IDLE only)
//   pos_x, pos_y   signed absolute tool position
//   busyH          state not IDLE or queue not empty
//   doneH          one-cycle pulse when a segment retires
//   faultH         watchdog fault latched
//   q_count        queued segment count
//   seg_cnt        retired segment count (wraps)
//   state_o        current FSM state (debug)
// -----------------------------------------------------------------------------
module seg_scheduler #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                    pulse_clk,
  input  logic                    sys_rstH,
  seg_scheduler_if.slave          bus,
  input  logic                    abortH,
  input  logic                    fault_clrH,
  input  logic                    pos_ldH,
  output logic [15:0]             pos_x,
  output logic [15:0]             pos_y,
  output logic                    busyH,
  output logic                    doneH,
  output logic                    faultH,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic [15:0]             seg_cnt,
  output logic [2:0]              state_o
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RUN   = 3'd2,
    S_GAP   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   xe_q, xe_d, ye_q, ye_d;
  logic [15:0]   posx_q, posx_d, posy_q, posy_d;
  logic [15:0]   segcnt_q, segcnt_d;
  logic [15:0]   wd_q, wd_d, gap_q, gap_d;
  logic          chg_q, chg_d, done_q, done_d, fault_q, fault_d, busy_q, busy_d;

  logic [31:0]   head;
  logic          head_zero, ready, push, pop, retire;

  assign head      = mem_q[rd_q];
  assign head_zero = (head == 32'd0);
  // Ready looks only at registers plus abortH/pos_ldH, so it never depends on
  // seg_validH.
  assign ready     = (cnt_q < DEPTH_C) & ~fault_q & ~abortH & ~pos_ldH;
  assign push      = bus.seg_validH & ready;

  // State register
  always_ff @(posedge pulse_clk) begin
    if (sys_rstH) begin
      state_q  <= S_IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      posx_q   <= '0;
      posy_q   <= '0;
      segcnt_q <= '0;
      wd_q     <= '0;
      gap_q    <= '0;
      chg_q    <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      segcnt_q <= segcnt_d;
      wd_q     <= wd_d;
      gap_q    <= gap_d;
      chg_q    <= chg_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
    end
  end

  // Queue storage: contents need no reset, the pointers define validity.
  always_ff @(posedge pulse_clk) begin
    if (push) mem_q[wr_q] <= {bus.seg_x, bus.seg_y};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    retire  = 1'b0;
    wd_d    = wd_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if ((cnt_q != '0) && !abortH) begin
          pop = 1'b1;
          // A (0,0) segment has nothing to draw: retire it on the spot.
          if (head_zero) retire  = 1'b1;
          else           state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      S_RUN: begin
        // draw_overH takes priority over a coincident timeout.
        if (bus.draw_overH) begin
          state_d = S_GAP;
          retire  = 1'b1;
          gap_d   = '0;
        end else begin
          wd_d = wd_q + 16'd1;
          if (wd_d == TIMEOUT_C) state_d = S_FAULT;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      S_FAULT: begin
        if (fault_clrH) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue pointers and occupancy; abort empties the queue and drops any push.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (abortH) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    chg_d    = (state_d == S_ISSUE);
    fault_d  = (state_d == S_FAULT);
    busy_d   = (state_d != S_IDLE) | (cnt_d != '0);
    done_d   = retire;
    segcnt_d = segcnt_q + {15'd0, retire};
    xe_d     = xe_q;
    ye_d     = ye_q;
    if (pop && !head_zero) begin
      xe_d = head[31:16];
      ye_d = head[15:0];
    end
    // A load overrides any step pulses in the same cycle.
    if (pos_ldH && (state_q == S_IDLE)) begin
      posx_d = bus.seg_x;
      posy_d = bus.seg_y;
    end else begin
      posx_d = posx_q + {15'd0, bus.X_acc} - {15'd0, bus.X_dec};
      posy_d = posy_q + {15'd0, bus.Y_acc} - {15'd0, bus.Y_dec};
    end
  end

  assign bus.seg_readyH    = ready;
  assign bus.Xe            = xe_q;
  assign bus.Ye            = ye_q;
  assign bus.change_readyH = chg_q;
  assign pos_x             = posx_q;
  assign pos_y             = posy_q;
  assign busyH             = busy_q;
  assign doneH             = done_q;
  assign faultH            = fault_q;
  assign q_count           = cnt_q;
  assign seg_cnt           = segcnt_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_seg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg_scheduler
// Directed bench for seg_scheduler with a behavioural interpolator. Issued
// endpoints are checked against a queue of expected segments filled as pushes
// are accepted.
// -----------------------------------------------------------------------------
module tb_seg_scheduler;
  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 20;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        abortH = 1'b0, fault_clrH = 1'b0, pos_ldH = 1'b0;
  logic [15:0] pos_x, pos_y, seg_cnt;
  logic        busyH, doneH, faultH;
  logic [2:0]  q_count;
  logic [2:0]  state;

  seg_scheduler_if bus();

  seg_scheduler #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .pulse_clk (clk),
    .sys_rstH  (rst),
    .bus       (bus),
    .abortH    (abortH),
    .fault_clrH(fault_clrH),
    .pos_ldH   (pos_ldH),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .busyH     (busyH),
    .doneH     (doneH),
    .faultH    (faultH),
    .q_count   (q_count),
    .seg_cnt   (seg_cnt),
    .state_o   (state)
  );

  // Step pulses come from the interpolator model (m_*) or directly from the
  // main sequence (t_*).
  logic m_xacc = 1'b0, m_xdec = 1'b0, m_yacc = 1'b0, m_ydec = 1'b0, m_draw = 1'b0;
  logic t_xacc = 1'b0, t_xdec = 1'b0, t_yacc = 1'b0, t_ydec = 1'b0;
  assign bus.X_acc      = m_xacc | t_xacc;
  assign bus.X_dec      = m_xdec | t_xdec;
  assign bus.Y_acc      = m_yacc | t_yacc;
  assign bus.Y_dec      = m_ydec | t_ydec;
  assign bus.draw_overH = m_draw;

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          chg_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_px = 16'd0, exp_py = 16'd0;
  bit          draw_en = 1'b1;
  int          last_draw = -1;
  bit          backlog = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (doneH) done_cnt <= done_cnt + 1;
    if (bus.change_readyH) chg_cnt <= chg_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural interpolator: one step per cycle for |Xe|/|Ye| cycles, then
  // draw_overH after 8 cycles (suppressed when draw_en is low).
  initial begin
    logic signed [15:0] tx, ty;
    logic [31:0]        e;
    forever begin
      @(negedge clk);
      if (bus.change_readyH) begin
        tx = bus.Xe;
        ty = bus.Ye;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("issue_xy", {tx, ty}, e);
        end
        if (last_draw >= 0) begin
          if (backlog) check("gap_exact", 32'(cyc - last_draw), 32'(GAP + 1));
          else         check("gap_min", 32'(cyc - last_draw >= GAP + 1), 32'd1);
          last_draw = -1;
        end
        for (int i = 0; i < 8; i++) begin
          m_xacc = (tx > 0) && (i < tx);
          m_xdec = (tx < 0) && (i < -tx);
          m_yacc = (ty > 0) && (i < ty);
          m_ydec = (ty < 0) && (i < -ty);
          @(negedge clk);
        end
        m_xacc = 1'b0; m_xdec = 1'b0; m_yacc = 1'b0; m_ydec = 1'b0;
        if (draw_en) begin
          m_draw    = 1'b1;
          last_draw = cyc + 1;
          backlog   = (q_count != 3'd0);
          @(negedge clk);
          m_draw = 1'b0;
        end
      end
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_seg(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    bus.seg_x      = x;
    bus.seg_y      = y;
    bus.seg_validH = 1'b1;
    #1;
    while (!bus.seg_readyH && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("push_ready", bus.seg_readyH, 1'b1);
    if (bus.seg_readyH) begin
      if (x != 16'd0 || y != 16'd0) exp_q.push_back({x, y});
      exp_px = exp_px + x;
      exp_py = exp_py + y;
    end
    @(negedge clk);
    bus.seg_validH = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!doneH && n < budget) begin
      @(negedge clk); n++;
    end
    check("wait_done", doneH, 1'b1);
  endtask

  task automatic wait_not_busy(input int budget);
    int n = 0;
    while (busyH && n < budget) begin
      @(negedge clk); n++;
    end
    check("wait_idle", busyH, 1'b0);
    @(negedge clk);
  endtask

  task automatic pos_load(input logic [15:0] x, input logic [15:0] y, input logic step);
    pos_ldH   = 1'b1;
    bus.seg_x = x;
    bus.seg_y = y;
    t_xacc    = step;
    @(negedge clk);
    pos_ldH = 1'b0;
    t_xacc  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  // Directed sequence
  initial begin
    int t0;
    bus.seg_validH = 1'b0;
    bus.seg_x      = 16'd0;
    bus.seg_y      = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_q_count", q_count, 0);
    check("rst_change", bus.change_readyH, 0);
    check("rst_xe", bus.Xe, 0);
    check("rst_ye", bus.Ye, 0);
    check("rst_pos_x", pos_x, 0);
    check("rst_pos_y", pos_y, 0);
    check("rst_busy", busyH, 0);
    check("rst_done", doneH, 0);
    check("rst_fault", faultH, 0);
    check("rst_seg_cnt", seg_cnt, 0);
    check("rst_ready", bus.seg_readyH, 1);
    check("rst_state", state, 0);

    // Single segment (5,3)
    last_draw = -1;
    push_seg(16'd5, 16'd3);
    check("t1_q_after_push", q_count, 1);
    check("t1_change_early", bus.change_readyH, 0);
    check("t1_busy", busyH, 1);
    tick();
    check("t1_change", bus.change_readyH, 1);
    check("t1_xe", bus.Xe, 16'd5);
    check("t1_ye", bus.Ye, 16'd3);
    check("t1_q_popped", q_count, 0);
    tick();
    check("t1_change_one_cycle", bus.change_readyH, 0);
    check("t1_state_run", state, 2);
    wait_done(40);
    check("t1_seg_cnt", seg_cnt, 1);
    wait_not_busy(40);
    check("t1_pos_x", pos_x, 16'd5);
    check("t1_pos_y", pos_y, 16'd3);
    check("t1_chg_cnt", chg_cnt, 1);
    check("t1_done_cnt", done_cnt, 1);

    // Full queue: first segment running, four more fill the queue, sixth stalls
    last_draw = -1;
    push_seg(16'd1, 16'd1);
    push_seg(16'd2, 16'hFFFF);
    push_seg(16'hFFFD, 16'd2);
    push_seg(16'd4, 16'd0);
    push_seg(16'd0, 16'hFFFB);
    check("t2_q_full", q_count, 4);
    check("t2_ready_low", bus.seg_readyH, 0);
    t0 = cyc;
    push_seg(16'hFFFE, 16'hFFFE);
    check("t2_push_stalled", 32'(cyc - t0 > 1), 1);
    wait_not_busy(400);
    check("t2_chg_cnt", chg_cnt, 7);
    check("t2_done_cnt", done_cnt, 7);
    check("t2_seg_cnt", seg_cnt, 7);
    check("t2_pos_x", pos_x, exp_px);
    check("t2_pos_y", pos_y, exp_py);
    check("t2_sb_empty", exp_q.size(), 0);

    // Negative and zero-length segments
    last_draw = -1;
    pos_load(16'd0, 16'd0, 1'b0);
    exp_px = 16'd0;
    exp_py = 16'd0;
    check("t3_pos_cleared", {pos_x, pos_y}, 32'd0);
    push_seg(16'hFFFC, 16'hFFFE);
    push_seg(16'd0, 16'd0);
    wait_not_busy(100);
    check("t3_pos_x", pos_x, 16'hFFFC);
    check("t3_pos_y", pos_y, 16'hFFFE);
    check("t3_chg_cnt", chg_cnt, 8);
    check("t3_done_cnt", done_cnt, 9);
    check("t3_seg_cnt", seg_cnt, 9);

    // Abort during RUN of the first of three segments
    last_draw = -1;
    push_seg(16'd2, 16'd2);
    push_seg(16'd3, 16'd1);
    push_seg(16'd1, 16'd3);
    check("t4_state_run", state, 2);
    check("t4_q_before", q_count, 2);
    abortH = 1'b1;
    tick();
    abortH = 1'b0;
    check("t4_q_flushed", q_count, 0);
    check("t4_still_run", state, 2);
    check("t4_busy", busyH, 1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    exp_px = exp_px - 16'd4;
    exp_py = exp_py - 16'd4;
    wait_done(40);
    check("t4_busy_in_gap", busyH, 1);
    repeat (GAP) tick();
    check("t4_busy_fell", busyH, 0);
    check("t4_state_idle", state, 0);
    repeat (5) tick();
    check("t4_chg_cnt", chg_cnt, 9);
    check("t4_seg_cnt", seg_cnt, 10);
    check("t4_pos_x", pos_x, exp_px);
    check("t4_pos_y", pos_y, exp_py);

    // Watchdog: draw_overH withheld, a second segment waits in the queue
    last_draw = -1;
    draw_en = 1'b0;
    push_seg(16'd3, 16'd3);
    push_seg(16'd1, 16'd2);
    check("t5_change", bus.change_readyH, 1);
    repeat (TIMEOUT) tick();
    check("t5_no_fault_yet", faultH, 0);
    check("t5_state_run", state, 2);
    tick();
    check("t5_fault", faultH, 1);
    check("t5_ready_low", bus.seg_readyH, 0);
    check("t5_state_fault", state, 4);
    check("t5_q_kept", q_count, 1);
    draw_en    = 1'b1;
    fault_clrH = 1'b1;
    tick();
    fault_clrH = 1'b0;
    check("t5_fault_clr", faultH, 0);
    check("t5_state_idle", state, 0);
    check("t5_ready_back", bus.seg_readyH, 1);
    tick();
    check("t5_reissue", bus.change_readyH, 1);
    check("t5_xe", bus.Xe, 16'd1);
    check("t5_ye", bus.Ye, 16'd2);
    wait_done(40);
    wait_not_busy(40);
    check("t5_seg_cnt", seg_cnt, 11);
    check("t5_chg_cnt", chg_cnt, 11);
    check("t5_pos_x", pos_x, exp_px);
    check("t5_pos_y", pos_y, exp_py);

    // Position load and wrap
    pos_load(16'h7FFF, 16'd0, 1'b0);
    check("t6_ld_x", pos_x, 16'h7FFF);
    check("t6_ld_y", pos_y, 16'd0);
    t_xacc = 1'b1;
    tick();
    t_xacc = 1'b0;
    check("t6_wrap", pos_x, 16'h8000);
    t_xacc = 1'b1;
    t_xdec = 1'b1;
    tick();
    t_xacc = 1'b0;
    t_xdec = 1'b0;
    check("t6_acc_dec_cancel", pos_x, 16'h8000);
    t_ydec = 1'b1;
    tick();
    t_ydec = 1'b0;
    check("t6_y_dec_wrap", pos_y, 16'hFFFF);
    pos_load(16'h1234, 16'h0042, 1'b1);
    check("t6_ld_ignores_step", pos_x, 16'h1234);
    check("t6_ld_y2", pos_y, 16'h0042);

    check("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
